// File: rtl/bilinear_scaler_wide_gen.sv
// Sequential Q8.8 bilinear scaler over a LANES-wide packed source RAM.
// Define BILIN_PERF_CNT_EN to build the read/transfer/stall counters.
module bilinear_scaler_wide_gen #(
    parameter int AW    = 10,
    parameter int LANES = 4,
    parameter int PAW   = AW + $clog2(LANES)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               i_abort,
    input  logic               i_step_en,
    input  logic               i_step_pulse,
    input  logic [15:0]        i_in_w,
    input  logic [15:0]        i_in_h,
    input  logic [15:0]        i_out_w,
    input  logic [15:0]        i_out_h,
    input  logic [15:0]        i_step_x_q88,
    input  logic [15:0]        i_step_y_q88,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [AW-1:0]      rd_addr0,
    input  logic [LANES*8-1:0] rd_data0,
    output logic [AW-1:0]      rd_addr1,
    input  logic [LANES*8-1:0] rd_data1,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PAW-1:0]     out_addr,
    output logic [7:0]         out_data,
    output logic [31:0]        o_rd_words,
    output logic [31:0]        o_wr_pix,
    output logic [31:0]        o_stall_cyc
);
    localparam int LW = $clog2(LANES);
    localparam int PW = AW + LW;

    typedef enum logic [3:0] {
        S_IDLE, S_CFG, S_FETCH0, S_CAP0, S_FETCH1, S_CAP1,
        S_CALC, S_OUT, S_STEP, S_ADV, S_DONE
    } state_t;

    state_t         r_state;
    logic [15:0]    r_in_w, r_in_h, r_out_w, r_out_h;
    logic [15:0]    r_step_x, r_step_y;
    logic           r_step_en;
    logic [23:0]    r_sx, r_sy;
    logic [15:0]    r_ox, r_oy;
    logic [7:0]     r_tl, r_tr, r_bl, r_br;
    logic           r_busy, r_done, r_err, r_out_valid;
    logic [PAW-1:0] r_out_addr;
    logic [7:0]     r_out_data;

    logic           w_bad;
    logic [15:0]    w_xraw, w_yraw, w_xi, w_yi;
    logic           w_xclp, w_yclp;
    logic [7:0]     w_fx, w_fy;
    logic [PW-1:0]  w_p0, w_p1;
    logic [LW-1:0]  w_lane0, w_lane1, w_nl0, w_nl1;
    logic [AW-1:0]  w_word0, w_word1;
    logic           w_str0, w_str1;
    logic [16:0]    w_top, w_bot;
    logic [25:0]    w_acc;
    logic [7:0]     w_pix;
    logic [PAW-1:0] w_oaddr;
    logic           w_last_x, w_last_y;

    assign w_bad = (i_in_w < 16'd2) || (i_in_h < 16'd2) ||
                   (i_out_w == 16'd0) || (i_out_h == 16'd0);

    // Clamp keeps the 2x2 window inside the image; fraction pins to the right/bottom tap.
    assign w_xraw = r_sx[23:8];
    assign w_yraw = r_sy[23:8];
    assign w_xclp = w_xraw >= r_in_w - 16'd1;
    assign w_yclp = w_yraw >= r_in_h - 16'd1;
    assign w_xi   = w_xclp ? r_in_w - 16'd2 : w_xraw;
    assign w_yi   = w_yclp ? r_in_h - 16'd2 : w_yraw;
    assign w_fx   = w_xclp ? 8'hFF : r_sx[7:0];
    assign w_fy   = w_yclp ? 8'hFF : r_sy[7:0];

    assign w_p0    = PW'(w_yi * r_in_w + w_xi);
    assign w_p1    = w_p0 + PW'(r_in_w);
    assign w_lane0 = w_p0[LW-1:0];
    assign w_lane1 = w_p1[LW-1:0];
    assign w_word0 = w_p0[PW-1:LW];
    assign w_word1 = w_p1[PW-1:LW];
    assign w_str0  = &w_lane0;
    assign w_str1  = &w_lane1;
    assign w_nl0   = w_lane0 + LW'(1);
    assign w_nl1   = w_lane1 + LW'(1);

    assign rd_addr0 = (r_state == S_FETCH1 && w_str0) ? w_word0 + AW'(1) : w_word0;
    assign rd_addr1 = (r_state == S_FETCH1 && w_str1) ? w_word1 + AW'(1) : w_word1;

    assign w_top = 17'(r_tl) * (17'd256 - 17'(w_fx)) + 17'(r_tr) * 17'(w_fx);
    assign w_bot = 17'(r_bl) * (17'd256 - 17'(w_fx)) + 17'(r_br) * 17'(w_fx);
    assign w_acc = 26'(w_top) * (26'd256 - 26'(w_fy)) +
                   26'(w_bot) * 26'(w_fy) + 26'd32768;
    assign w_pix = (w_acc[25:16] > 10'd255) ? 8'hFF : w_acc[23:16];

    assign w_oaddr  = PAW'(r_oy * r_out_w + r_ox);
    assign w_last_x = (r_ox == r_out_w - 16'd1);
    assign w_last_y = (r_oy == r_out_h - 16'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_in_w      <= '0;
            r_in_h      <= '0;
            r_out_w     <= '0;
            r_out_h     <= '0;
            r_step_x    <= '0;
            r_step_y    <= '0;
            r_step_en   <= 1'b0;
            r_sx        <= '0;
            r_sy        <= '0;
            r_ox        <= '0;
            r_oy        <= '0;
            r_tl        <= '0;
            r_tr        <= '0;
            r_bl        <= '0;
            r_br        <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_addr  <= '0;
            r_out_data  <= '0;
        end else begin
            r_done <= 1'b0;
            if (r_state != S_IDLE && i_abort) begin
                r_state     <= S_IDLE;
                r_busy      <= 1'b0;
                r_out_valid <= 1'b0;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_in_w    <= i_in_w;
                            r_in_h    <= i_in_h;
                            r_out_w   <= i_out_w;
                            r_out_h   <= i_out_h;
                            r_step_x  <= i_step_x_q88;
                            r_step_y  <= i_step_y_q88;
                            r_step_en <= i_step_en;
                            r_err     <= w_bad;
                            if (w_bad) begin
                                r_done <= 1'b1;
                            end else begin
                                r_busy  <= 1'b1;
                                r_state <= S_CFG;
                            end
                        end
                    end
                    S_CFG: begin
                        r_sx    <= '0;
                        r_sy    <= '0;
                        r_ox    <= '0;
                        r_oy    <= '0;
                        r_state <= S_FETCH0;
                    end
                    S_FETCH0: r_state <= S_CAP0;
                    S_CAP0: begin
                        r_tl    <= rd_data0[w_lane0*8 +: 8];
                        r_bl    <= rd_data1[w_lane1*8 +: 8];
                        r_tr    <= rd_data0[w_nl0*8 +: 8];
                        r_br    <= rd_data1[w_nl1*8 +: 8];
                        r_state <= (w_str0 || w_str1) ? S_FETCH1 : S_CALC;
                    end
                    S_FETCH1: r_state <= S_CAP1;
                    S_CAP1: begin
                        if (w_str0) r_tr <= rd_data0[7:0];
                        if (w_str1) r_br <= rd_data1[7:0];
                        r_state <= S_CALC;
                    end
                    S_CALC: begin
                        r_out_data  <= w_pix;
                        r_out_addr  <= w_oaddr;
                        r_out_valid <= 1'b1;
                        r_state     <= S_OUT;
                    end
                    S_OUT: begin
                        if (out_ready) begin
                            r_out_valid <= 1'b0;
                            r_state     <= r_step_en ? S_STEP : S_ADV;
                        end
                    end
                    S_STEP: if (i_step_pulse) r_state <= S_ADV;
                    S_ADV: begin
                        if (!w_last_x) begin
                            r_ox    <= r_ox + 16'd1;
                            r_sx    <= r_sx + 24'(r_step_x);
                            r_state <= S_FETCH0;
                        end else if (!w_last_y) begin
                            r_ox    <= '0;
                            r_oy    <= r_oy + 16'd1;
                            r_sx    <= '0;
                            r_sy    <= r_sy + 24'(r_step_y);
                            r_state <= S_FETCH0;
                        end else begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                    S_DONE: r_state <= S_IDLE;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign out_valid = r_out_valid;
    assign out_addr  = r_out_addr;
    assign out_data  = r_out_data;

`ifdef BILIN_PERF_CNT_EN
    logic [31:0] r_rd_words, r_wr_pix, r_stall_cyc;
    logic        w_go;

    assign w_go = (r_state == S_IDLE) && start && !w_bad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_words  <= '0;
            r_wr_pix    <= '0;
            r_stall_cyc <= '0;
        end else if (w_go) begin
            r_rd_words  <= '0;
            r_wr_pix    <= '0;
            r_stall_cyc <= '0;
        end else begin
            if (!i_abort && r_state == S_FETCH0)
                r_rd_words <= r_rd_words + 32'd2;
            else if (!i_abort && r_state == S_FETCH1)
                r_rd_words <= r_rd_words + 32'(w_str0) + 32'(w_str1);
            if (!i_abort && r_state == S_OUT && r_out_valid && out_ready)
                r_wr_pix <= r_wr_pix + 32'd1;
            if (r_out_valid && !out_ready)
                r_stall_cyc <= r_stall_cyc + 32'd1;
        end
    end

    assign o_rd_words  = r_rd_words;
    assign o_wr_pix    = r_wr_pix;
    assign o_stall_cyc = r_stall_cyc;
`else
    assign o_rd_words  = '0;
    assign o_wr_pix    = '0;
    assign o_stall_cyc = '0;
`endif

endmodule

// File: tb/tb_bilinear_scaler_wide_gen.sv
// Randomized bench for bilinear_scaler_wide_gen against a pixel-level reference.
// Covers ramp, upscale, backpressure, single-step, abort, config errors, reset.
module tb_bilinear_scaler_wide_gen;
    localparam int AW    = 10;
    localparam int LANES = 4;
    localparam int PAW   = 12;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic               i_abort = 1'b0;
    logic               i_step_en = 1'b0;
    logic               i_step_pulse = 1'b0;
    logic [15:0]        i_in_w = '0, i_in_h = '0, i_out_w = '0, i_out_h = '0;
    logic [15:0]        i_step_x_q88 = '0, i_step_y_q88 = '0;
    logic               busy, done, err;
    logic [AW-1:0]      rd_addr0, rd_addr1;
    logic [LANES*8-1:0] rd_data0, rd_data1;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [PAW-1:0]     out_addr;
    logic [7:0]         out_data;
    logic [31:0]        o_rd_words, o_wr_pix, o_stall_cyc;

    logic [7:0] src [0:4095];
    int inw, inh, outw, outh, stx, sty;
    int n_tests = 0;
    int n_fail = 0;

    bilinear_scaler_wide_gen #(.AW(AW), .LANES(LANES), .PAW(PAW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .i_abort(i_abort),
        .i_step_en(i_step_en), .i_step_pulse(i_step_pulse),
        .i_in_w(i_in_w), .i_in_h(i_in_h), .i_out_w(i_out_w), .i_out_h(i_out_h),
        .i_step_x_q88(i_step_x_q88), .i_step_y_q88(i_step_y_q88),
        .busy(busy), .done(done), .err(err),
        .rd_addr0(rd_addr0), .rd_data0(rd_data0),
        .rd_addr1(rd_addr1), .rd_data1(rd_data1),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_data(out_data),
        .o_rd_words(o_rd_words), .o_wr_pix(o_wr_pix), .o_stall_cyc(o_stall_cyc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rd_data0 <= {src[int'(rd_addr0)*4+3], src[int'(rd_addr0)*4+2],
                     src[int'(rd_addr0)*4+1], src[int'(rd_addr0)*4]};
        rd_data1 <= {src[int'(rd_addr1)*4+3], src[int'(rd_addr1)*4+2],
                     src[int'(rd_addr1)*4+1], src[int'(rd_addr1)*4]};
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic void ref_xy(input int ox, input int oy,
                                   output int xi, output int yi,
                                   output int fx, output int fy);
        int sx, sy;
        sx = (ox * stx) & 'hFFFFFF;
        sy = (oy * sty) & 'hFFFFFF;
        xi = sx >> 8;
        fx = sx & 255;
        yi = sy >> 8;
        fy = sy & 255;
        if (xi >= inw - 1) begin xi = inw - 2; fx = 255; end
        if (yi >= inh - 1) begin yi = inh - 2; fy = 255; end
    endfunction

    function automatic int ref_pix(input int ox, input int oy);
        int xi, yi, fx, fy, tl, tr, bl, br, top, bot, res;
        ref_xy(ox, oy, xi, yi, fx, fy);
        tl  = src[yi*inw + xi];
        tr  = src[yi*inw + xi + 1];
        bl  = src[(yi+1)*inw + xi];
        br  = src[(yi+1)*inw + xi + 1];
        top = tl * (256 - fx) + tr * fx;
        bot = bl * (256 - fx) + br * fx;
        res = (top * (256 - fy) + bot * fy + 32768) >> 16;
        return (res > 255) ? 255 : res;
    endfunction

    function automatic int ref_words(input int ox, input int oy);
        int xi, yi, fx, fy, p;
        ref_xy(ox, oy, xi, yi, fx, fy);
        p = yi * inw + xi;
        return 2 + int'((p % LANES) == LANES-1) + int'(((p + inw) % LANES) == LANES-1);
    endfunction

    task automatic perf_chk(input longint words, input int pix, input int stalls);
`ifdef BILIN_PERF_CNT_EN
        chk("rd_words", o_rd_words, words);
        chk("wr_pix", o_wr_pix, pix);
        chk("stall_cyc", o_stall_cyc, stalls);
`else
        chk("rd_words_off", o_rd_words, 0);
        chk("wr_pix_off", o_wr_pix, 0);
        chk("stall_cyc_off", o_stall_cyc, 0);
`endif
    endtask

    // mode 0: always ready, 1: random ready, 2: 10-cycle stall on pixel 5
    task automatic run_frame(input int mode, input bit step, input int abort_at, input bit spot);
        int nxt, since, hold, stalls, pend, ox, oy, bad;
        longint words;
        bit rdy, fin, aborted;
        nxt = 0; since = 0; hold = 0; stalls = 0; pend = 1;
        words = 0; fin = 0; aborted = 0;
        @(negedge clk);
        i_in_w = 16'(inw); i_in_h = 16'(inh);
        i_out_w = 16'(outw); i_out_h = 16'(outh);
        i_step_x_q88 = 16'(stx); i_step_y_q88 = 16'(sty);
        i_step_en = step; out_ready = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_up", busy, 1);
        chk("err_clr", err, 0);
        for (int cyc = 0; cyc < 30000 && !fin; cyc++) begin
            if (cyc > 0) @(negedge clk);
            since++;
            i_abort = 1'b0;
            i_step_pulse = 1'b0;
            if (aborted) begin
                chk("abort_busy", busy, 0);
                chk("abort_valid", out_valid, 0);
                bad = 0;
                for (int k = 0; k < 20; k++) begin
                    @(negedge clk);
                    if (done || busy || out_valid) bad++;
                end
                chk("abort_quiet", bad, 0);
                perf_chk(words + ref_words(nxt % outw, nxt / outw), nxt, stalls);
                fin = 1;
            end else if (done) begin
                chk("done_busy", busy, 0);
                chk("xfers", nxt, outw * outh);
                if (!step) chk("done_lat", since <= 3, 1);
                perf_chk(words, nxt, stalls);
                @(negedge clk);
                chk("done_pulse", done, 0);
                fin = 1;
            end else begin
                rdy = 1'b1;
                if (mode == 1) rdy = ($urandom_range(0, 3) != 0);
                if (mode == 2 && out_valid && nxt == 5 && hold < 10) begin
                    rdy = 1'b0;
                    hold++;
                    chk("stall_addr", out_addr, 5);
                    chk("stall_data", out_data, ref_pix(5 % outw, 5 / outw));
                end
                out_ready = rdy;
                start = (mode == 1 && nxt == 3 && since == 2);
                if (out_valid && !rdy) stalls++;
                if (out_valid && rdy) begin
                    ox = nxt % outw;
                    oy = nxt / outw;
                    chk("addr", out_addr, nxt & 12'hFFF);
                    chk("pix", out_data, ref_pix(ox, oy));
                    if (spot && nxt == 1)
                        chk("px10", out_data, (src[0] + src[1] + 1) >> 1);
                    if (step) chk("step_one", pend, 1);
                    pend = 0;
                    words += ref_words(ox, oy);
                    nxt++;
                    since = 0;
                end
                if (step && since == 10) begin
                    chk("step_hold", out_valid, 0);
                    i_step_pulse = 1'b1;
                    pend = 1;
                end
                if (step && since == 12) i_step_pulse = 1'b1;
                if (abort_at >= 0 && nxt == abort_at && since == 5) begin
                    i_abort = 1'b1;
                    aborted = 1;
                end
            end
        end
        start = 1'b0;
        i_abort = 1'b0;
        i_step_pulse = 1'b0;
        i_step_en = 1'b0;
        out_ready = 1'b1;
        if (!fin) chk("timeout", 0, 1);
    endtask

    task automatic run_err(input int w, input int h, input int ow, input int oh);
        int bad;
        @(negedge clk);
        i_in_w = 16'(w); i_in_h = 16'(h); i_out_w = 16'(ow); i_out_h = 16'(oh);
        i_step_x_q88 = 16'h0100; i_step_y_q88 = 16'h0100;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("err_set", err, 1);
        chk("err_done", done, 1);
        chk("err_busy", busy, 0);
        bad = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (busy || out_valid || done) bad++;
        end
        chk("err_quiet", bad, 0);
        chk("err_sticky", err, 1);
    endtask

    initial begin
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_oaddr", out_addr, 0);
        chk("rst_odata", out_data, 0);
        chk("rst_cnt", {o_rd_words, o_wr_pix} | 64'(o_stall_cyc), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 4096; i++) src[i] = 8'($urandom);
        inw = 4; inh = 4; outw = 4; outh = 4; stx = 'h100; sty = 'h100;
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 4; x++) src[y*4 + x] = 8'(16*y + 4*x);
        run_frame(0, 0, -1, 0);

        for (int i = 0; i < 4096; i++) src[i] = 8'($urandom);
        inw = 16; inh = 16; outw = 32; outh = 32; stx = 'h80; sty = 'h80;
        run_frame(1, 0, -1, 1);

        inw = 8; inh = 8; outw = 8; outh = 8; stx = 'h100; sty = 'h100;
        run_frame(2, 0, -1, 0);

        inw = 6; inh = 5; outw = 4; outh = 3; stx = 'h140; sty = 'h180;
        run_frame(0, 1, -1, 0);

        inw = 16; inh = 8; outw = 16; outh = 8; stx = 'h100; sty = 'h100;
        run_frame(0, 0, 7, 0);
        run_frame(0, 0, -1, 0);

        run_err(1, 4, 4, 4);
        run_err(4, 4, 4, 0);

        @(negedge clk);
        i_in_w = 16'd20; i_in_h = 16'd12; i_out_w = 16'd9; i_out_h = 16'd7;
        i_step_x_q88 = 16'h2A0; i_step_y_q88 = 16'h200;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_valid", out_valid, 0);
        chk("arst_err", err, 0);
        @(negedge clk);
        rst_n = 1'b1;

        inw = 20; inh = 12; outw = 9; outh = 7; stx = 'h2A0; sty = 'h200;
        run_frame(1, 0, -1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
